// File: rtl/aer_pkg.sv
// Shared definitions for the AER output sink: handshake FSM states and default bus width.
package aer_pkg;

  localparam int unsigned AerWidthDefault = 12;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StAck
  } aer_state_e;

endpackage

// File: rtl/aer_evt_fifo.sv
// Synchronous first-word-fall-through event FIFO; head reads 0 while empty.
module aer_evt_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data;
  end

endmodule

// File: rtl/aer_out_sink.sv
// AER output responder: 4-phase REQ/ACK with programmable ACK latency, event FIFO and counter.
// Define AER_OUT_SINK_DROP_EN to handshake and drop events when the FIFO is full (else stall).
module aer_out_sink
  import aer_pkg::*;
#(
  parameter int unsigned AER_WIDTH  = AerWidthDefault,
  parameter int unsigned ACK_DELAY  = 6,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [AER_WIDTH-1:0] AEROUT_ADDR,
  input  logic                 AEROUT_REQ,
  output logic                 AEROUT_ACK,
  input  logic                 SAMPLE_CLR,
  input  logic                 EVT_RD,
  output logic [AER_WIDTH-1:0] EVT_DATA,
  output logic                 EVT_VALID,
  output logic [CNT_WIDTH-1:0] EVT_CNT,
  output logic                 OVERFLOW
);

  localparam int unsigned DlyW = (ACK_DELAY > 0) ? $clog2(ACK_DELAY + 1) : 1;

  aer_state_e          state_q, state_d;
  logic [DlyW-1:0]     dly_q, dly_d;
  logic                ack_q, ack_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic                has_space, req_ok, accept;

  assign fifo_pop  = EVT_RD && !fifo_empty;
  assign has_space = !fifo_full || fifo_pop;
  assign fifo_push = accept && has_space;

`ifdef AER_OUT_SINK_DROP_EN
  assign req_ok = AEROUT_REQ;
`else
  assign req_ok = AEROUT_REQ && has_space;
`endif

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    ack_d   = ack_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_ok) begin
          accept  = 1'b1;
          dly_d   = DlyW'(ACK_DELAY);
          state_d = StDelay;
        end
      end
      StDelay: begin
        if (dly_q == '0) begin
          ack_d   = 1'b1;
          state_d = StAck;
        end else begin
          dly_d = dly_q - DlyW'(1);
        end
      end
      StAck: begin
        if (!AEROUT_REQ) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A clear coinciding with an accept counts that accept into the new sample.
  always_comb begin
    cnt_d = cnt_q;
    if (SAMPLE_CLR) begin
      cnt_d = accept ? CNT_WIDTH'(1) : '0;
    end else if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      dly_q   <= '0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef AER_OUT_SINK_DROP_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (SAMPLE_CLR)             ovf_d = 1'b0;
    if (accept && !has_space)   ovf_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign OVERFLOW = ovf_q;
`else
  assign OVERFLOW = 1'b0;
`endif

  aer_evt_fifo #(
    .WIDTH (AER_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .data  (AEROUT_ADDR),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (EVT_DATA)
  );

  assign AEROUT_ACK = ack_q;
  assign EVT_VALID  = !fifo_empty;
  assign EVT_CNT    = cnt_q;

endmodule

// File: tb/tb_aer_out_sink.sv
// Bench for aer_out_sink: default instance plus a small instance (no delay, depth 4, 2-bit count).
module tb_aer_out_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic [11:0] addr  [2];
  logic        rd    [2];
  logic        clr   [2];
  logic        ack   [2];
  logic [11:0] data  [2];
  logic        valid [2];
  logic        ovf   [2];
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  aer_out_sink u_dut_a (
    .CLK         (clk),
    .RST         (rst),
    .AEROUT_ADDR (addr[0]),
    .AEROUT_REQ  (req[0]),
    .AEROUT_ACK  (ack[0]),
    .SAMPLE_CLR  (clr[0]),
    .EVT_RD      (rd[0]),
    .EVT_DATA    (data[0]),
    .EVT_VALID   (valid[0]),
    .EVT_CNT     (cnt_a),
    .OVERFLOW    (ovf[0])
  );

  aer_out_sink #(
    .ACK_DELAY  (0),
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (2)
  ) u_dut_b (
    .CLK         (clk),
    .RST         (rst),
    .AEROUT_ADDR (addr[1]),
    .AEROUT_REQ  (req[1]),
    .AEROUT_ACK  (ack[1]),
    .SAMPLE_CLR  (clr[1]),
    .EVT_RD      (rd[1]),
    .EVT_DATA    (data[1]),
    .EVT_VALID   (valid[1]),
    .EVT_CNT     (cnt_b),
    .OVERFLOW    (ovf[1])
  );

  // Reference model: per-instance event queue, pending-ACK cycle stamp and plain counters.
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          m_dly   [2] = '{6, 0};
  int          m_depth [2] = '{16, 4};
  int          m_cmax  [2] = '{65535, 3};
  bit          m_ack   [2];
  bit          m_pend  [2];
  int          m_ackat [2];
  int          m_cnt   [2];
  bit          m_ovf   [2];
  logic [11:0] q0 [$];
  logic [11:0] q1 [$];

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [11:0] qfront(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int i, input logic [11:0] a);
    if (i == 0) q0.push_back(a);
    else        q1.push_back(a);
  endtask

  task automatic qpop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic model_step(input int i);
    bit pop_ok, space, accept, store;
    if (rst) begin
      m_ack[i] = 0; m_pend[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
      if (i == 0) q0.delete();
      else        q1.delete();
      return;
    end
    pop_ok = rd[i] && (qsize(i) > 0);
    space  = (qsize(i) < m_depth[i]) || pop_ok;
    accept = 0;
    store  = 0;
    if (m_ack[i]) begin
      if (!req[i]) m_ack[i] = 0;
    end else if (m_pend[i]) begin
      if (cyc == m_ackat[i]) begin
        m_ack[i]  = 1;
        m_pend[i] = 0;
      end
    end else if (req[i]) begin
      if (space) begin
        accept = 1;
        store  = 1;
      end
`ifdef AER_OUT_SINK_DROP_EN
      else accept = 1;
`endif
    end
    if (clr[i]) begin
      m_cnt[i] = accept ? 1 : 0;
      m_ovf[i] = 0;
    end else if (accept && (m_cnt[i] < m_cmax[i])) begin
      m_cnt[i]++;
    end
    if (accept && !store) m_ovf[i] = 1;
    if (accept) begin
      m_pend[i]  = 1;
      m_ackat[i] = cyc + m_dly[i] + 1;
    end
    if (pop_ok) qpop(i);
    if (store)  qpush(i, addr[i]);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ack%0d", i), 32'(ack[i]), 32'(m_ack[i]));
      chk($sformatf("valid%0d", i), 32'(valid[i]), 32'(qsize(i) > 0));
      chk($sformatf("data%0d", i), 32'(data[i]), (qsize(i) > 0) ? 32'(qfront(i)) : 32'd0);
      chk($sformatf("cnt%0d", i), (i == 0) ? 32'(cnt_a) : 32'(cnt_b), 32'(m_cnt[i]));
      chk($sformatf("ovf%0d", i), 32'(ovf[i]), 32'(m_ovf[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  // Full 4-phase event; lat counts edges from capture to ACK high.
  task automatic hs(input int i, input logic [11:0] a, input int bound,
                    output int lat, output bit got);
    int ticks = 0;
    req[i]  = 1'b1;
    addr[i] = a;
    got     = 0;
    while (!got && ticks < bound) begin
      tick();
      ticks++;
      if (m_pend[i] || m_ack[i]) addr[i] = 12'($urandom);
      if (ack[i]) got = 1;
    end
    lat = ticks - 1;
    if (got) begin
      req[i] = 1'b0;
      tick();
      chk("ack_release", 32'(ack[i]), 32'd0);
    end
  endtask

  initial begin
    int          lat;
    bit          got;
    int          n;
    logic [11:0] exp_q [4];

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; addr[i] = '0; rd[i] = 1'b0; clr[i] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ack", 32'(ack[0]), 32'd0);
    chk("rst_valid", 32'(valid[0]), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    for (int k = 0; k < 7; k++) tick();

    // Default timing: ACK seven edges after capture.
    hs(0, 12'h05A, 20, lat, got);
    chk("t1_got", 32'(got), 32'd1);
    chk("t1_lat", 32'(lat), 32'd7);
    chk("t1_data", 32'(data[0]), 32'h05A);
    chk("t1_valid", 32'(valid[0]), 32'd1);
    chk("t1_cnt", 32'(cnt_a), 32'd1);

    // Zero delay, back-to-back events, in-order pop.
    for (int k = 1; k <= 3; k++) begin
      hs(1, 12'(k), 10, lat, got);
      chk("t2_lat", 32'(lat), 32'd1);
    end
    chk("t2_cnt", 32'(cnt_b), 32'd3);
    for (int k = 1; k <= 3; k++) begin
      chk("t2_pop", 32'(data[1]), 32'(k));
      rd[1] = 1'b1;
      tick();
      rd[1] = 1'b0;
    end
    chk("t2_empty", 32'(valid[1]), 32'd0);
    rd[0] = 1'b1;
    tick();
    rd[0] = 1'b0;
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    chk("t2_clr", 32'(cnt_b), 32'd0);

    // Fill depth-4 FIFO, then a fifth event.
    for (int k = 1; k <= 4; k++) begin
      hs(1, 12'h100 + 12'(k), 10, lat, got);
      chk("t3_fill", 32'(got), 32'd1);
    end
    hs(1, 12'h0AB, 6, lat, got);
`ifdef AER_OUT_SINK_DROP_EN
    chk("t3_drop_got", 32'(got), 32'd1);
    chk("t3_drop_lat", 32'(lat), 32'd1);
    chk("t3_ovf", 32'(ovf[1]), 32'd1);
    exp_q = '{12'h101, 12'h102, 12'h103, 12'h104};
`else
    chk("t3_stall_got", 32'(got), 32'd0);
    rd[1] = 1'b1;
    tick();
    rd[1] = 1'b0;
    n = 0;
    while (!ack[1] && n < 5) begin
      tick();
      n++;
    end
    chk("t3_stall_lat", 32'(n), 32'd1);
    req[1] = 1'b0;
    tick();
    exp_q = '{12'h102, 12'h103, 12'h104, 12'h0AB};
`endif
    chk("t3_cnt_sat", 32'(cnt_b), 32'd3);
    rd[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_drain", 32'(data[1]), 32'(exp_q[k]));
      tick();
    end
    rd[1] = 1'b0;
    chk("t3_empty", 32'(valid[1]), 32'd0);
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    chk("t3_clr_ovf", 32'(ovf[1]), 32'd0);
    chk("t3_clr_cnt", 32'(cnt_b), 32'd0);

    // Clear on the capture edge still counts that capture.
    req[0]  = 1'b1;
    addr[0] = 12'h3C3;
    clr[0]  = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("t4_clr_cap", 32'(cnt_a), 32'd1);
    n = 0;
    while (!ack[0] && n < 12) begin
      tick();
      n++;
    end
    chk("t4_ack", 32'(ack[0]), 32'd1);
    req[0] = 1'b0;
    tick();

    // Reset in the middle of the delay.
    req[0]  = 1'b1;
    addr[0] = 12'h777;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    req[0] = 1'b0;
    tick();
    chk("t5_ack", 32'(ack[0]), 32'd0);
    chk("t5_valid", 32'(valid[0]), 32'd0);
    hs(0, 12'h246, 20, lat, got);
    chk("t5_lat", 32'(lat), 32'd7);
    chk("t5_data", 32'(data[0]), 32'h246);

    // Random protocol-compliant traffic on both instances.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i]  = 1'b1;
          addr[i] = 12'($urandom);
        end
        rd[i]  = ($urandom_range(0, 3) == 0);
        clr[i] = ($urandom_range(0, 15) == 0);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aer_out_sink.md
Name: aer_out_sink

Overview:
- Parametrised AER output responder and event buffer, the successor to the fixed 6-cycle pulse-ACK generator in the test top.
- Implements a full 4-phase REQ/ACK handshake on the core's AEROUT bus, with programmable ACK latency.
- Captures each output-spike address into a FIFO and counts events per sample.
- Sits between the ODIN_ffstdp AEROUT port and the test or readout logic.

Parameters:
- AER_WIDTH, 12: width of the AER address bus.
- ACK_DELAY, 6: cycles added between REQ capture and ACK assertion (0 allowed).
- FIFO_DEPTH, 16: event FIFO depth; power of 2, ≥ 2.
- CNT_WIDTH, 16: width of the per-sample event counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- AEROUT_ADDR  in  AER_WIDTH  spike address from the core.
- AEROUT_REQ  in  1  request from the core.
- AEROUT_ACK  out  1  acknowledge to the core (registered).
- SAMPLE_CLR  in  1  one-cycle pulse (ONE_SAMPLE_FINISH); clears EVT_CNT and OVERFLOW.
- EVT_RD  in  1  pop the FIFO head.
- EVT_DATA  out  AER_WIDTH  FIFO head, first-word-fall-through.
- EVT_VALID  out  1  FIFO non-empty.
- EVT_CNT  out  CNT_WIDTH  events accepted since the last clear.
- OVERFLOW  out  1  sticky flag: event dropped (drop mode only).

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST.
- Reset values: AEROUT_ACK=0, EVT_VALID=0, EVT_DATA=0, EVT_CNT=0, OVERFLOW=0. FIFO empty, FSM in IDLE, delay counter 0.
- FSM states: IDLE, DELAY, ACK.
- IDLE:
  - REQ sampled high at edge t and FIFO has space: capture AEROUT_ADDR, push it to the FIFO, increment EVT_CNT, load counter=ACK_DELAY, go to DELAY.
  - FIFO has space when not full, or when full with EVT_RD high in the same cycle (simultaneous pop and push allowed).
  - FIFO full with no EVT_RD (stall mode): remain in IDLE with no capture. The core is back-pressured by the withheld ACK.
- DELAY: counter==0 → go to ACK and set AEROUT_ACK; otherwise decrement the counter.
- ACK latency: ACK rises at edge t+ACK_DELAY+1. ACK_DELAY=0 gives ACK at t+1; the default gives t+7, matching the legacy block.
- ACK state: hold ACK high until REQ is sampled low. At that edge clear ACK and go to IDLE.
  - A new REQ is accepted only from IDLE, so there is at least one cycle of ACK low between events.
- The address is sampled only at the IDLE capture edge; address changes during DELAY or ACK are ignored.
- FIFO: EVT_RD while empty is ignored. EVT_DATA is valid only while EVT_VALID is high.
- EVT_CNT saturates at 2^CNT_WIDTH−1.
- SAMPLE_CLR coinciding with an accept gives EVT_CNT=1 on the next cycle. SAMPLE_CLR does not flush the FIFO.
- RST asserted mid-handshake: ACK drops at the reset edge and the FIFO is flushed. The core must treat this as an aborted event.

Optional Feature:
- Macro: AER_OUT_SINK_DROP_EN.
- Defined (drop mode):
  - REQ with the FIFO full and no EVT_RD is still handshaken through DELAY/ACK, but the address is discarded.
  - OVERFLOW is set (sticky until SAMPLE_CLR or RST) and EVT_CNT still increments.
- Undefined (stall mode): stall as described above. OVERFLOW is tied to 0.

Decomposition:
- Shared package aer_pkg: FSM state encoding (IDLE/DELAY/ACK) and default AER_WIDTH.
- One sub-module, aer_evt_fifo: synchronous first-word-fall-through FIFO.
  - Parameters: width and depth.
  - Ports: push, pop, full, empty, head.
- The FSM, delay counter and event counter stay in aer_out_sink.

Test Plan:
- Default params; REQ rises at edge 10 with ADDR=0x05A and is held until ACK → ACK high at edge 17; REQ low at 20 → ACK low at 20; EVT_DATA=0x05A, EVT_VALID=1, EVT_CNT=1.
- ACK_DELAY=0; three back-to-back 4-phase events 0x001/0x002/0x003 → each ACK one cycle after capture; FIFO pops in order; EVT_CNT=3.
- FIFO_DEPTH=4, no reads, 5 events in stall mode → 5th REQ gets no ACK; one EVT_RD → 5th captured, ACK follows ACK_DELAY+1 later.
- Same sequence with AER_OUT_SINK_DROP_EN → 5th event ACKed, OVERFLOW=1, EVT_CNT=5, FIFO holds the first 4; SAMPLE_CLR → OVERFLOW=0, EVT_CNT=0.
- SAMPLE_CLR on the same edge as a capture → EVT_CNT=1. CNT_WIDTH=2 with 5 events → EVT_CNT saturates at 3.
- RST pulse during the DELAY state → ACK stays 0, EVT_VALID=0, FSM in IDLE. The next REQ is handled normally.
